dram_write_combiner: RTL and testbench
======================================

// Module: dram_write_combiner
// PURPOSE
//  Sits directly downstream of the DRAM write collector output stage, on its dramw rdy/ack channel.
//  Coalesces consecutive partial (masked) cache-line writes to the same global address into one
//  line write, cutting DRAM write transactions. Presents a rdy/ack channel with the same line format.
//  Contains one combining entry plus one output register.
// PARAMETERS
//  GBW      TauCfg::GLOBAL_ADDR_BW  global line address width
//  DBW      TauCfg::DATA_BW         lane data width
//  CSIZE    TauCfg::CACHE_SIZE      lanes per line
//  TIMEOUT  TauCfg::DRAMW_TIMEOUT (16)  idle cycles before auto-flush; 4b..8b counter, >=1
// PORTS
//  i_clk         in   1          clock
//  i_rst         in   1          synchronous, active-high reset
//  in_rdy        in   1          upstream line valid
//  in_ack        out  1          line accepted this cycle
//  i_dramwa      in   GBW        line address
//  i_dramwd      in   DBW x CSIZE  lane data
//  i_dramw_mask  in   CSIZE      lane write enables
//  i_flush       in   1          level: drain entry, block new input
//  o_idle        out  1          entry and output register both empty
//  dramw_rdy     out  1          output line valid
//  dramw_ack     in   1          DRAM consumed output
//  o_dramwa      out  GBW        output address
//  o_dramwd      out  DBW x CSIZE  output data
//  o_dramw_mask  out  CSIZE      output mask
// BEHAVIOUR
//  Handshake: transfer when rdy&&ack same cycle. Acks are combinational, asserted only with the
//   matching rdy. Senders hold payload stable until ack.
//  State: entry {ev, ea, ed[], em}; output {ov = dramw_rdy, o_*}; cnt idle counter.
//  Reset (sync, i_rst=1 at posedge): ev=ov=0, cnt=0; o_dramwa/o_dramwd/o_dramw_mask=0.
//   o_idle=1; in_ack=0 while i_rst high. Reset mid-operation discards entry and output line.
//  out_free = !ov || dramw_ack.
//  in_ack = in_rdy && !i_flush && (!ev || hit || out_free), where hit = ev && (i_dramwa==ea).
//  Accept, ev=0: load entry, em=mask, ed=data. Load is unconditional; mask=0 is still loaded.
//  Accept, hit: merge lanes. ed[i]=mask[i]?din[i]:ed[i], em|=mask. Stays in entry, cnt=0.
//  Accept, miss: entry moves to output (ov=1), incoming loads entry. Same cycle, 1-cycle latency.
//  Miss with !out_free: in_ack=0 (stall), entry unchanged.
//  Flush: i_flush && ev && out_free -> entry to output, ev=0.
//   i_flush with ev=0 is a no-op apart from blocking input.
//  Entry with em==0 is dropped (ev=0) instead of moved to output. dramw_rdy never shows an all-zero mask.
//  Output: dramw_ack clears ov unless a new line moves in the same cycle (then ov stays 1, new payload).
//  Latency: accepted line reaches dramw_rdy at earliest 1 cycle after a miss, flush or timeout event.
//  Order: lines leave in acceptance order. A merged line leaves at its first-accept order.
//  Simultaneous: a hit accept on a timeout cycle wins. Merge happens, cnt=0, no flush that cycle.
//  o_idle = !ev && !ov (registered state only).
// CONFIGURATION
//  DRAMW_COMBINE_TIMEOUT_EN defined:
//   cnt counts cycles with ev && !in_ack, saturates at TIMEOUT. Cleared on any accept or when ev=0.
//   When cnt==TIMEOUT && out_free: flush entry.
//  Undefined: no counter, no timeout flush. Entry leaves only on a miss or i_flush.
//  Upstream must assert i_flush at end of a tile.
// STRUCTURE
//  TauCfg: add DRAMW_TIMEOUT. GLOBAL_ADDR_BW, DATA_BW and CACHE_SIZE already there.
//  Sub-module dramw_lane_merge: combinational per-lane select plus mask OR; used for the hit path.
//  Control is a 2-bit {ev,ov} occupancy FSM: EMPTY, HOLD, OUT, HOLD_OUT.
//   Transitions follow the accept/flush/ack rules above.
// TESTING
//  1 Writes A=0x40 mask 0x000F, then A=0x40 mask 0x00F0, then i_flush
//    -> one dramw line, a=0x40, mask 0x00FF, lanes 0-7 match.
//  2 Writes 0x40 m=0x1, 0x80 m=0x2 back-to-back, dramw_ack tied 1
//    -> 0x40 m=0x1 out 1 cycle after 2nd accept; 0x80 out after flush.
//  3 Overlap merge: 0x40 lane0=5 m=0x1, then 0x40 lane0=9 m=0x1
//    -> output lane0=9, mask 0x1.
//  4 Stall: dramw_ack=0, writes 0x40, 0x80, 0xC0 -> third in_ack=0 until dramw_ack.
//    Then 0x40, 0x80 out in order, no loss.
//  5 Timeout (TIMEOUT_EN, TIMEOUT=4): one write 0x40, in_rdy low
//    -> dramw_rdy rises 5 cycles after accept. Without macro, never rises.
//  6 Reset mid-op with ev=ov=1 -> next cycle dramw_rdy=0, o_*=0, o_idle=1.
//    Zero-mask write + flush -> no output line.

Source files
------------

// File: rtl/dram_write_combiner_pkg.sv
// Shared configuration and types for the DRAM write combiner.
//   GLOBAL_ADDR_BW : global line address width
//   DATA_BW        : lane data width
//   CACHE_SIZE     : lanes per cache line
//   DRAMW_TIMEOUT  : idle cycles before the combining entry auto-flushes
//   occ_state_e    : {ev,ov} occupancy of the combining entry / output register
package dram_write_combiner_pkg;

  localparam int GLOBAL_ADDR_BW = 32;
  localparam int DATA_BW        = 16;
  localparam int CACHE_SIZE     = 16;
  localparam int DRAMW_TIMEOUT  = 16;

  // Encoding is {ev, ov}: bit 1 = entry valid, bit 0 = output valid.
  typedef enum logic [1:0] {
    EMPTY    = 2'b00,
    OUT      = 2'b01,
    HOLD     = 2'b10,
    HOLD_OUT = 2'b11
  } occ_state_e;

  function automatic occ_state_e occ_state(input logic ev, input logic ov);
    return occ_state_e'({ev, ov});
  endfunction

endpackage

// File: rtl/dramw_lane_merge.sv
// Combinational lane merge for a same-address (hit) write.
//   ent_data / ent_mask : current combining entry
//   wr_data  / wr_mask  : incoming partial line
//   merged_data         : per lane, incoming data where wr_mask is set, else entry data
//   merged_mask         : ent_mask | wr_mask
module dramw_lane_merge
  import dram_write_combiner_pkg::*;
#(
  parameter int DBW   = DATA_BW,
  parameter int CSIZE = CACHE_SIZE
) (
  input  logic [DBW*CSIZE-1:0] ent_data,
  input  logic [CSIZE-1:0]     ent_mask,
  input  logic [DBW*CSIZE-1:0] wr_data,
  input  logic [CSIZE-1:0]     wr_mask,
  output logic [DBW*CSIZE-1:0] merged_data,
  output logic [CSIZE-1:0]     merged_mask
);

  always_comb begin
    merged_data = ent_data;
    for (int i = 0; i < CSIZE; i++) begin
      if (wr_mask[i]) merged_data[i*DBW +: DBW] = wr_data[i*DBW +: DBW];
    end
  end

  assign merged_mask = ent_mask | wr_mask;

endmodule

// File: rtl/dram_write_combiner.sv
// DRAM write combiner: coalesces consecutive masked line writes to the same
// global address into one line write. One combining entry plus one output
// register; lines leave in first-accept order.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   in_rdy / in_ack         upstream line valid / accepted (combinational)
//   i_dramwa/_dramwd/_mask  upstream line address, lane data, lane enables
//   i_flush                 level: drain entry, block new input
//   o_idle                  entry and output register both empty
//   dramw_rdy / dramw_ack   output line valid / consumed by DRAM
//   o_dramwa/_dramwd/_mask  output line
// Optional feature: define DRAMW_COMBINE_TIMEOUT_EN to flush an entry that has
// been idle for TIMEOUT cycles. Without it, the entry leaves only on a miss
// or i_flush.
module dram_write_combiner
  import dram_write_combiner_pkg::*;
#(
  parameter int GBW     = GLOBAL_ADDR_BW,
  parameter int DBW     = DATA_BW,
  parameter int CSIZE   = CACHE_SIZE,
  parameter int TIMEOUT = DRAMW_TIMEOUT
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 in_rdy,
  output logic                 in_ack,
  input  logic [GBW-1:0]       i_dramwa,
  input  logic [DBW*CSIZE-1:0] i_dramwd,
  input  logic [CSIZE-1:0]     i_dramw_mask,
  input  logic                 i_flush,
  output logic                 o_idle,
  output logic                 dramw_rdy,
  input  logic                 dramw_ack,
  output logic [GBW-1:0]       o_dramwa,
  output logic [DBW*CSIZE-1:0] o_dramwd,
  output logic [CSIZE-1:0]     o_dramw_mask
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("dram_write_combiner: TIMEOUT must be in 1..255");
  end

  occ_state_e           state;
  logic                 ev, ov;
  logic [GBW-1:0]       ea;
  logic [DBW*CSIZE-1:0] ed;
  logic [CSIZE-1:0]     em;

  logic                 hit, out_free, tmo, move, push_out;
  logic [DBW*CSIZE-1:0] merged_data;
  logic [CSIZE-1:0]     merged_mask;

  assign ev        = state[1];
  assign ov        = state[0];
  assign dramw_rdy = ov;
  assign o_idle    = (state == EMPTY);

  dramw_lane_merge #(
    .DBW   (DBW),
    .CSIZE (CSIZE)
  ) u_lane_merge (
    .ent_data    (ed),
    .ent_mask    (em),
    .wr_data     (i_dramwd),
    .wr_mask     (i_dramw_mask),
    .merged_data (merged_data),
    .merged_mask (merged_mask)
  );

`ifdef DRAMW_COMBINE_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt;

  // Counts cycles the entry sits without an accept; saturates at CNT_MAX.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (!ev || in_ack) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tmo = (cnt == CNT_MAX);
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    hit      = ev && (i_dramwa == ea);
    out_free = !ov || dramw_ack;
    in_ack   = in_rdy && !i_rst && !i_flush && (!ev || hit || out_free);
    // Entry leaves on a miss accept, or on flush/timeout when nothing is
    // accepted (a hit accept on a timeout cycle keeps the entry).
    move     = ev && ((in_ack && !hit) || (!in_ack && out_free && (i_flush || tmo)));
    // An all-zero-mask entry is dropped rather than presented downstream.
    push_out = move && (em != '0);
  end

  // Occupancy FSM: {ev, ov}
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= EMPTY;
    end else begin
      state <= occ_state(in_ack || (ev && !move), push_out || (ov && !dramw_ack));
    end
  end

  // Combining entry payload; only meaningful while ev is set.
  always_ff @(posedge i_clk) begin
    if (in_ack) begin
      ea <= i_dramwa;
      if (hit) begin
        ed <= merged_data;
        em <= merged_mask;
      end else begin
        ed <= i_dramwd;
        em <= i_dramw_mask;
      end
    end
  end

  // Output register payload
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_dramwa     <= '0;
      o_dramwd     <= '0;
      o_dramw_mask <= '0;
    end else if (push_out) begin
      o_dramwa     <= ea;
      o_dramwd     <= ed;
      o_dramw_mask <= em;
    end
  end

endmodule

// File: tb/tb_dram_write_combiner.sv
// Self-checking bench for dram_write_combiner: directed vector table, hand
// sequences for merge/timeout/reset corners, and a randomized run against a
// line-level reference model (entry + output queue).
module tb_dram_write_combiner;

  localparam int GBW     = 32;
  localparam int DBW     = 16;
  localparam int CSIZE   = 16;
  localparam int TIMEOUT = 4;
  localparam int DW      = DBW * CSIZE;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_rdy;
  logic            in_ack;
  logic [GBW-1:0]  dramwa_in;
  logic [DW-1:0]   dramwd_in;
  logic [CSIZE-1:0] mask_in;
  logic            flush;
  logic            idle;
  logic            dramw_rdy;
  logic            dramw_ack;
  logic [GBW-1:0]  dramwa_out;
  logic [DW-1:0]   dramwd_out;
  logic [CSIZE-1:0] mask_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dram_write_combiner #(
    .GBW(GBW), .DBW(DBW), .CSIZE(CSIZE), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .in_rdy       (in_rdy),
    .in_ack       (in_ack),
    .i_dramwa     (dramwa_in),
    .i_dramwd     (dramwd_in),
    .i_dramw_mask (mask_in),
    .i_flush      (flush),
    .o_idle       (idle),
    .dramw_rdy    (dramw_rdy),
    .dramw_ack    (dramw_ack),
    .o_dramwa     (dramwa_out),
    .o_dramwd     (dramwd_out),
    .o_dramw_mask (mask_out)
  );

  typedef struct {
    logic            rdy;
    logic [GBW-1:0]  a;
    logic [CSIZE-1:0] m;
    logic            flush;
    logic            ack;
    logic            x_ack;
    logic            x_rdy;
    logic [GBW-1:0]  x_a;
    logic [CSIZE-1:0] x_m;
    logic            x_idle;
  } vec_t;

  typedef struct {
    logic [GBW-1:0]  a;
    logic [DW-1:0]   d;
    logic [CSIZE-1:0] m;
  } line_t;

  vec_t tbl[$];

  task automatic add(input logic rdy, input logic [GBW-1:0] a, input logic [CSIZE-1:0] m,
                     input logic fl, input logic ack, input logic x_ack, input logic x_rdy,
                     input logic [GBW-1:0] x_a, input logic [CSIZE-1:0] x_m, input logic x_idle);
    vec_t v;
    v.rdy = rdy; v.a = a; v.m = m; v.flush = fl; v.ack = ack;
    v.x_ack = x_ack; v.x_rdy = x_rdy; v.x_a = x_a; v.x_m = x_m; v.x_idle = x_idle;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mkdata(input logic [GBW-1:0] a);
    logic [DW-1:0] d;
    for (int i = 0; i < CSIZE; i++) d[i*DBW +: DBW] = {a[7:0], 8'(i)};
    return d;
  endfunction

  function automatic logic [DW-1:0] filldata(input logic [DBW-1:0] v);
    logic [DW-1:0] d;
    for (int i = 0; i < CSIZE; i++) d[i*DBW +: DBW] = v;
    return d;
  endfunction

  task automatic drive(input logic rdy, input logic [GBW-1:0] a, input logic [CSIZE-1:0] m,
                       input logic [DW-1:0] d, input logic fl, input logic ack);
    in_rdy = rdy; dramwa_in = a; mask_in = m; dramwd_in = d; flush = fl; dramw_ack = ack;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // reference model state
  logic  ent_v;
  line_t ent;
  line_t outq[$];
  int    cnt_m;

  initial begin
    logic [GBW-1:0] addrs[3];
    logic  pend;
    line_t cur;
    logic  out_free, hit, exp_ack, fire, old_v, tmo_m;

    addrs[0] = 32'h40; addrs[1] = 32'h80; addrs[2] = 32'hC0;

    // Directed table: tests 1, 2 and 4 back to back.
    add(1'b1, 32'h40, 16'h000F, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  16'h0,    1'b1);
    add(1'b1, 32'h40, 16'h00F0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  16'h0,    1'b0);
    add(1'b0, 32'h0,  16'h0,    1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  16'h0,    1'b0);
    add(1'b0, 32'h0,  16'h0,    1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 16'h00FF, 1'b0);
    add(1'b0, 32'h0,  16'h0,    1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  16'h0,    1'b1);
    add(1'b1, 32'h40, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  16'h0,    1'b1);
    add(1'b1, 32'h80, 16'h0002, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  16'h0,    1'b0);
    add(1'b0, 32'h0,  16'h0,    1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 16'h0001, 1'b0);
    add(1'b0, 32'h0,  16'h0,    1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  16'h0,    1'b0);
    add(1'b0, 32'h0,  16'h0,    1'b0, 1'b1, 1'b0, 1'b1, 32'h80, 16'h0002, 1'b0);
    add(1'b0, 32'h0,  16'h0,    1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  16'h0,    1'b1);
    add(1'b1, 32'h40, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  16'h0,    1'b1);
    add(1'b1, 32'h80, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  16'h0,    1'b0);
    add(1'b1, 32'hC0, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 16'h0001, 1'b0);
    add(1'b1, 32'hC0, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 16'h0001, 1'b0);
    add(1'b1, 32'hC0, 16'h0004, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 16'h0001, 1'b0);
    add(1'b0, 32'h0,  16'h0,    1'b0, 1'b1, 1'b0, 1'b1, 32'h80, 16'h0002, 1'b0);
    add(1'b0, 32'h0,  16'h0,    1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  16'h0,    1'b0);
    add(1'b0, 32'h0,  16'h0,    1'b0, 1'b1, 1'b0, 1'b1, 32'hC0, 16'h0004, 1'b0);
    add(1'b0, 32'h0,  16'h0,    1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  16'h0,    1'b1);

    // Reset, with in_rdy high to confirm in_ack is held low.
    rst = 1'b1;
    drive(1'b1, 32'h40, 16'h1, filldata(16'h1), 1'b0, 1'b0);
    next_cycle();
    next_cycle();
    #2;
    chk("reset_in_ack", in_ack, 0);
    chk("reset_rdy", dramw_rdy, 0);
    chk("reset_idle", idle, 1);
    chk("reset_addr", dramwa_out, 0);
    chk("reset_mask", mask_out, 0);
    rst = 1'b0;
    drive(1'b0, 32'h0, 16'h0, '0, 1'b0, 1'b1);
    next_cycle();

    foreach (tbl[k]) begin
      drive(tbl[k].rdy, tbl[k].a, tbl[k].m, mkdata(tbl[k].a), tbl[k].flush, tbl[k].ack);
      #2;
      chk($sformatf("tbl%0d_in_ack", k), in_ack, tbl[k].x_ack);
      chk($sformatf("tbl%0d_rdy", k), dramw_rdy, tbl[k].x_rdy);
      chk($sformatf("tbl%0d_idle", k), idle, tbl[k].x_idle);
      if (tbl[k].x_rdy) begin
        chk($sformatf("tbl%0d_addr", k), dramwa_out, tbl[k].x_a);
        chk($sformatf("tbl%0d_mask", k), mask_out, tbl[k].x_m);
      end
      next_cycle();
    end

    // Overlapping lane merge: later lane data wins, untouched lanes keep load data.
    drive(1'b1, 32'h40, 16'h0001, filldata(16'd5), 1'b0, 1'b1);
    #2; chk("ovl_ack1", in_ack, 1);
    next_cycle();
    drive(1'b1, 32'h40, 16'h0001, filldata(16'd9), 1'b0, 1'b1);
    #2; chk("ovl_ack2", in_ack, 1);
    next_cycle();
    drive(1'b0, 32'h0, 16'h0, '0, 1'b1, 1'b1);
    next_cycle();
    drive(1'b0, 32'h0, 16'h0, '0, 1'b0, 1'b1);
    #2;
    chk("ovl_rdy", dramw_rdy, 1);
    chk("ovl_mask", mask_out, 16'h0001);
    chk("ovl_lane0", dramwd_out[DBW-1:0], 16'd9);
    chk("ovl_lane1", dramwd_out[2*DBW-1:DBW], 16'd5);
    next_cycle();
    next_cycle();

    // Timeout: single write, then idle input.
    drive(1'b1, 32'h40, 16'h0001, filldata(16'd7), 1'b0, 1'b1);
    next_cycle();
    drive(1'b0, 32'h0, 16'h0, '0, 1'b0, 1'b1);
`ifdef DRAMW_COMBINE_TIMEOUT_EN
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("tmo_rdy_c%0d", k), dramw_rdy, (k == 5) ? 1 : 0);
    end
`else
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      chk($sformatf("notmo_rdy_c%0d", k), dramw_rdy, 0);
    end
`endif
    drive(1'b0, 32'h0, 16'h0, '0, 1'b1, 1'b1);
    next_cycle();
    drive(1'b0, 32'h0, 16'h0, '0, 1'b0, 1'b1);
    next_cycle();
    next_cycle();
    chk("tmo_drain_idle", idle, 1);

    // Reset with entry and output both occupied.
    drive(1'b1, 32'h40, 16'h0001, filldata(16'd3), 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 32'h80, 16'h0002, filldata(16'd4), 1'b0, 1'b0);
    next_cycle();
    chk("rmid_pre_rdy", dramw_rdy, 1);
    chk("rmid_pre_idle", idle, 0);
    rst = 1'b1;
    drive(1'b1, 32'hC0, 16'h0004, filldata(16'd6), 1'b0, 1'b0);
    #2; chk("rmid_in_ack", in_ack, 0);
    next_cycle();
    rst = 1'b0;
    drive(1'b0, 32'h0, 16'h0, '0, 1'b0, 1'b1);
    #2;
    chk("rmid_rdy", dramw_rdy, 0);
    chk("rmid_addr", dramwa_out, 0);
    chk("rmid_data", dramwd_out, 0);
    chk("rmid_mask", mask_out, 0);
    chk("rmid_idle", idle, 1);
    next_cycle();

    // Zero-mask write followed by flush produces nothing.
    drive(1'b1, 32'h40, 16'h0000, filldata(16'd8), 1'b0, 1'b1);
    #2; chk("zm_ack", in_ack, 1);
    next_cycle();
    drive(1'b0, 32'h0, 16'h0, '0, 1'b1, 1'b1);
    next_cycle();
    drive(1'b0, 32'h0, 16'h0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      #2; chk($sformatf("zm_rdy%0d", k), dramw_rdy, 0);
      next_cycle();
    end
    chk("zm_idle", idle, 1);

    // Randomized run against the line-level model.
    ent_v = 1'b0; cnt_m = 0; outq.delete(); pend = 1'b0;
    cur.a = '0; cur.d = '0; cur.m = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!pend && $urandom_range(0, 99) < 60) begin
        pend  = 1'b1;
        cur.a = addrs[$urandom_range(0, 2)];
        cur.d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        cur.m = ($urandom_range(0, 9) == 0) ? 16'h0 : 16'($urandom);
      end
      drive(pend, cur.a, cur.m, cur.d, ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0);
      #2;
      out_free = (outq.size() == 0) || dramw_ack;
      hit      = ent_v && (dramwa_in == ent.a);
      exp_ack  = pend && !flush && (!ent_v || hit || out_free);
      chk("rnd_in_ack", in_ack, exp_ack);
      chk("rnd_rdy", dramw_rdy, (outq.size() != 0) ? 1 : 0);
      chk("rnd_idle", idle, (!ent_v && outq.size() == 0) ? 1 : 0);
      if (outq.size() != 0) begin
        chk("rnd_addr", dramwa_out, outq[0].a);
        chk("rnd_mask", mask_out, outq[0].m);
        chk("rnd_data", dramwd_out, outq[0].d);
      end
`ifdef DRAMW_COMBINE_TIMEOUT_EN
      tmo_m = (cnt_m == TIMEOUT);
`else
      tmo_m = 1'b0;
`endif
      old_v = ent_v;
      if (outq.size() != 0 && dramw_ack) void'(outq.pop_front());
      fire = ent_v && !exp_ack && out_free && (flush || tmo_m);
      if (exp_ack) begin
        if (hit) begin
          for (int i = 0; i < CSIZE; i++)
            if (cur.m[i]) ent.d[i*DBW +: DBW] = cur.d[i*DBW +: DBW];
          ent.m = ent.m | cur.m;
        end else begin
          if (ent_v && ent.m != 0) outq.push_back(ent);
          ent   = cur;
          ent_v = 1'b1;
        end
        pend = 1'b0;
      end else if (fire) begin
        if (ent.m != 0) outq.push_back(ent);
        ent_v = 1'b0;
      end
      if (!old_v || exp_ack) cnt_m = 0;
      else if (cnt_m < TIMEOUT) cnt_m++;
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
